// File: rtl/eb_fifo.sv
// Elastic-buffer FIFO with a valid/ready handshake on both sides and registered-only flags.
// Define EB_FIFO_LEVEL_EN to add the level and almost_full ports.
module eb_fifo #(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AFULL_LVL = DEPTH - 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DWIDTH-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
`ifdef EB_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level,
  output logic                   almost_full
`endif
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = PW - 1;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              full, empty;
  logic              push, pop;

  // Each pointer carries one extra wrap bit so that full and empty stay distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) &&
                 (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);

  assign s_ready = !full;
  assign m_valid = !empty;
  assign m_data  = mem_q[rd_ptr_q[IW-1:0]];

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage clears on reset so that m_data reads zero while the FIFO is held in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q[IW-1:0]] <= s_data;
    end
  end

`ifdef EB_FIFO_LEVEL_EN
  assign level       = wr_ptr_q - rd_ptr_q;
  assign almost_full = (32'(level) >= AFULL_LVL);
`endif

endmodule
